// File: rtl/sha3_pkg.sv
// Shared Keccak-f[1600] lane and index types for the theta pipeline.
// Lane order on the load path is i = x + 5*y.
package sha3_pkg;
  localparam int LANE_W    = 64;
  localparam int NUM_COLS  = 5;
  localparam int NUM_ROWS  = 5;
  localparam int NUM_LANES = 25;

  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [2:0]        col_idx_t;
  typedef logic [2:0]        row_idx_t;

  localparam col_idx_t LAST_COL = col_idx_t'(NUM_COLS - 1);
  localparam row_idx_t LAST_ROW = row_idx_t'(NUM_ROWS - 1);
endpackage

// File: rtl/sha3_theta_parity_accumulator.sv
// Serial theta column-parity accumulator: 25 lanes in, C[0..4] out registered one cycle after the last lane.
// Only the final beat stalls, while the previous result is unconsumed. Optional macro: SHA3_THETA_PARITY_LAST_CHECK_EN.
module sha3_theta_parity_accumulator
  import sha3_pkg::*;
#(
  parameter string STYLE = "basic"
) (
  input  logic  clk,
  input  logic  rst,
  input  lane_t in_lane,
  input  logic  in_valid,
  output logic  in_ready,
  input  logic  in_abort,
`ifdef SHA3_THETA_PARITY_LAST_CHECK_EN
  input  logic  in_last,
  output logic  err,
`endif
  output lane_t term [NUM_COLS],
  output logic  out_valid,
  input  logic  out_ready
);

  if (STYLE != "basic") begin : g_style_chk
    $error("Logic style unsupported.");
  end
  if (NUM_COLS * NUM_ROWS != NUM_LANES) begin : g_geom_chk
    $error("Lane geometry inconsistent.");
  end

  col_idx_t col;
  row_idx_t row;
  lane_t    acc [NUM_COLS];
  logic     last_beat;
  logic     accept;

  assign last_beat = (row == LAST_ROW) && (col == LAST_COL);
  assign in_ready  = !(last_beat && out_valid && !out_ready);
  assign accept    = in_valid && in_ready && !in_abort;

  // Row 0 overwrites acc, so no clear cycle is needed between blocks or after abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
      for (int x = 0; x < NUM_COLS; x++) acc[x] <= '0;
    end else if (in_abort) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (row == '0) acc[col] <= in_lane;
      else           acc[col] <= acc[col] ^ in_lane;
      if (col == LAST_COL) begin
        col <= '0;
        row <= (row == LAST_ROW) ? row_idx_t'(0) : row_idx_t'(row + 3'd1);
      end else begin
        col <= col_idx_t'(col + 3'd1);
      end
    end
  end

  // Column 4 of the final beat bypasses acc so the result lands without a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int x = 0; x < NUM_COLS; x++) term[x] <= '0;
      out_valid <= 1'b0;
    end else if (accept && last_beat) begin
      for (int x = 0; x < NUM_COLS - 1; x++) term[x] <= acc[x];
      term[LAST_COL] <= acc[LAST_COL] ^ in_lane;
      out_valid      <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SHA3_THETA_PARITY_LAST_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (accept && (in_last != last_beat)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sha3_theta_parity_accumulator.sv
// Directed bench for the theta column-parity accumulator.
// Expected parities are hand-computed XORs of the lane patterns.
module tb_sha3_theta_parity_accumulator;
  import sha3_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  lane_t in_lane;
  logic  in_valid;
  logic  in_ready;
  logic  in_abort;
  lane_t term [NUM_COLS];
  logic  out_valid;
  logic  out_ready;
`ifdef SHA3_THETA_PARITY_LAST_CHECK_EN
  logic  in_last;
  logic  err;
`endif

  int tests = 0;
  int fails = 0;

  // C[x] for lanes i and for lanes i+100, i = 0..24
  lane_t exp_seq [NUM_COLS] = '{64'd20, 64'd9, 64'd14, 64'd3, 64'd8};
  lane_t exp_100 [NUM_COLS] = '{64'd104, 64'd109, 64'd114, 64'd119, 64'd124};

  always #5 clk = ~clk;

  sha3_theta_parity_accumulator #(.STYLE("basic")) dut (
    .clk       (clk),
    .rst       (rst),
    .in_lane   (in_lane),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_abort  (in_abort),
`ifdef SHA3_THETA_PARITY_LAST_CHECK_EN
    .in_last   (in_last),
    .err       (err),
`endif
    .term      (term),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic send_block(input lane_t base, input lane_t step, input int last_at);
    for (int i = 0; i < NUM_LANES; i++) begin
      in_valid = 1'b1;
      in_lane  = base + step * 64'(i);
`ifdef SHA3_THETA_PARITY_LAST_CHECK_EN
      in_last  = (i == last_at);
`endif
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
`ifdef SHA3_THETA_PARITY_LAST_CHECK_EN
    in_last  = 1'b0;
`endif
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    for (int x = 0; x < NUM_COLS; x++) begin
      tests++;
      if (term[x] !== 64'd0) begin fails++; $display("FAIL reset_term[%0d] got %h want 0", x, term[x]); end
    end
  endtask

  task automatic test_basic();
    drain();
    send_block(64'd0, 64'd1, 24);
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_out_valid got %b want 1", out_valid); end
    for (int x = 0; x < NUM_COLS; x++) begin
      tests++;
      if (term[x] !== exp_seq[x]) begin fails++; $display("FAIL basic_term[%0d] got %0d want %0d", x, term[x], exp_seq[x]); end
    end
  endtask

  task automatic test_ones_zeros();
    drain();
    send_block(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 24);
    for (int x = 0; x < NUM_COLS; x++) begin
      tests++;
      if (term[x] !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL ones_term[%0d] got %h want all ones", x, term[x]); end
    end
    send_block(64'd0, 64'd0, 24);
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL zeros_out_valid got %b want 1", out_valid); end
    for (int x = 0; x < NUM_COLS; x++) begin
      tests++;
      if (term[x] !== 64'd0) begin fails++; $display("FAIL zeros_term[%0d] got %h want 0", x, term[x]); end
    end
  endtask

  task automatic test_back_to_back();
    int n_out = 0;
    int first_at = -1;
    int second_at = -1;
    int rdy_drops = 0;
    drain();
    @(posedge clk); #1;
    for (int c = 0; c < 2 * NUM_LANES; c++) begin
      in_valid = 1'b1;
      in_lane  = (c < NUM_LANES) ? 64'(c) : 64'(c - NUM_LANES + 100);
`ifdef SHA3_THETA_PARITY_LAST_CHECK_EN
      in_last  = (c == 24) || (c == 49);
`endif
      if (in_ready !== 1'b1) rdy_drops++;
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        n_out++;
        if (first_at < 0) first_at = c; else second_at = c;
        for (int x = 0; x < NUM_COLS; x++) begin
          tests++;
          if (c < NUM_LANES && term[x] !== exp_seq[x]) begin fails++; $display("FAIL b2b_term1[%0d] got %0d want %0d", x, term[x], exp_seq[x]); end
          else if (c >= NUM_LANES && term[x] !== exp_100[x]) begin fails++; $display("FAIL b2b_term2[%0d] got %0d want %0d", x, term[x], exp_100[x]); end
        end
      end
    end
    in_valid = 1'b0;
`ifdef SHA3_THETA_PARITY_LAST_CHECK_EN
    in_last  = 1'b0;
`endif
    tests++;
    if (n_out !== 2) begin fails++; $display("FAIL b2b_count got %0d want 2", n_out); end
    tests++;
    if (first_at !== 24 || second_at !== 49) begin fails++; $display("FAIL b2b_timing got %0d,%0d want 24,49", first_at, second_at); end
    tests++;
    if (rdy_drops !== 0) begin fails++; $display("FAIL b2b_in_ready got %0d low cycles want 0", rdy_drops); end
  endtask

  task automatic test_backpressure();
    int early_drops = 0;
    drain();
    out_ready = 1'b0;
    send_block(64'd0, 64'd1, 24);
    for (int i = 0; i < NUM_LANES - 1; i++) begin
      in_valid = 1'b1;
      in_lane  = 64'(i + 100);
      if (in_ready !== 1'b1) early_drops++;
      @(posedge clk); #1;
    end
    tests++;
    if (early_drops !== 0) begin fails++; $display("FAIL bp_early_stall got %0d want 0", early_drops); end
    in_lane = 64'd124;
`ifdef SHA3_THETA_PARITY_LAST_CHECK_EN
    in_last = 1'b1;
`endif
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_stall got in_ready %b want 0", in_ready); end
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold got in_ready %b out_valid %b want 0 1", in_ready, out_valid); end
    for (int x = 0; x < NUM_COLS; x++) begin
      tests++;
      if (term[x] !== exp_seq[x]) begin fails++; $display("FAIL bp_term_held[%0d] got %0d want %0d", x, term[x], exp_seq[x]); end
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release got in_ready %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifdef SHA3_THETA_PARITY_LAST_CHECK_EN
    in_last  = 1'b0;
`endif
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid_kept got %b want 1", out_valid); end
    for (int x = 0; x < NUM_COLS; x++) begin
      tests++;
      if (term[x] !== exp_100[x]) begin fails++; $display("FAIL bp_term2[%0d] got %0d want %0d", x, term[x], exp_100[x]); end
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_abort();
    drain();
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_lane  = 64'hDEAD_BEEF_0000_0000 + 64'(i);
      @(posedge clk); #1;
    end
    in_abort = 1'b1;
    in_lane  = 64'h5555_AAAA_5555_AAAA;
    @(posedge clk); #1;
    in_abort = 1'b0;
    send_block(64'd0, 64'd1, 24);
    for (int x = 0; x < NUM_COLS; x++) begin
      tests++;
      if (term[x] !== exp_seq[x]) begin fails++; $display("FAIL abort_term[%0d] got %0d want %0d", x, term[x], exp_seq[x]); end
    end
    // Hold the result, load 12 beats, then reset asynchronously mid-cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_lane  = 64'hCAFE_0000_0000_0000 + 64'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #3 rst = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL async_rst_out_valid got %b want 0", out_valid); end
    for (int x = 0; x < NUM_COLS; x++) begin
      tests++;
      if (term[x] !== 64'd0) begin fails++; $display("FAIL async_rst_term[%0d] got %h want 0", x, term[x]); end
    end
    #2 rst = 1'b1;
    out_ready = 1'b1;
    send_block(64'd100, 64'd1, 24);
    for (int x = 0; x < NUM_COLS; x++) begin
      tests++;
      if (term[x] !== exp_100[x]) begin fails++; $display("FAIL post_rst_term[%0d] got %0d want %0d", x, term[x], exp_100[x]); end
    end
  endtask

`ifdef SHA3_THETA_PARITY_LAST_CHECK_EN
  task automatic test_last_check();
    drain();
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL err_clean got %b want 0", err); end
    send_block(64'd0, 64'd1, 23);
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL err_set got %b want 1", err); end
    tests++;
    if (term[0] !== exp_seq[0]) begin fails++; $display("FAIL err_data_term0 got %0d want %0d", term[0], exp_seq[0]); end
    send_block(64'd100, 64'd1, 24);
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL err_sticky got %b want 1", err); end
  endtask
`endif

  initial begin
    rst       = 1'b0;
    in_lane   = '0;
    in_valid  = 1'b0;
    in_abort  = 1'b0;
    out_ready = 1'b1;
`ifdef SHA3_THETA_PARITY_LAST_CHECK_EN
    in_last   = 1'b0;
`endif
    #12;
    test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_ones_zeros();
    test_back_to_back();
    test_backpressure();
    test_abort();
`ifdef SHA3_THETA_PARITY_LAST_CHECK_EN
    test_last_check();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
